dftprobe_chain: RTL
===================

Name: dftprobe_chain

Overview:
- Parametrised successor to the single-bit DFT test-data probe.
- Bundles NCH probe channels behind one capture/shift/update scan segment, so a single serial tdi/tdo pair can observe and force many control nodes.
- When ten is low, the block is functionally transparent (o = i).
- When ten is high, each o is driven from a registered update latch loaded through the scan chain.
- Sits between analog control logic (for example, the stepdown loop control) and the chip-level DFT scan path.

Parameters:
- NCH, 8, number of probe channels (1..64).
- RESET_VAL, '0, NCH-bit reset value of the update register.
- CNT_W, $clog2(NCH+1), shift counter width (derived, not overridable).

Ports:
- CELCLK  in  1  scan/probe clock
- CELRSTN  in  1  asynchronous active-low reset
- i  in  NCH  functional inputs
- o  out  NCH  probe outputs
- ten  in  1  test enable, selects update register onto o
- start  in  1  one-cycle request to run one capture-shift-update sequence
- tdi  in  1  serial scan data in
- tdo  out  1  serial scan data out
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse in the UPDATE state
- perr  out  1  parity error flag (see Optional Feature)
- CELG, CELSUB, CELV  in  1  ground, substrate and supply pins; no logic function; passed to cells only

Behaviour:
- Reset (CELRSTN low, asynchronous) sets:
  - FSM to IDLE
  - shreg to 0, upd to RESET_VAL, cnt to 0
  - busy, done, tdo, perr to 0
- Release of reset is synchronous to CELCLK.
- o = ten ? upd : i. This mux is purely combinational; ten has no clock latency.
- FSM states, encoding in package: IDLE, CAPTURE, SHIFT, UPDATE.
  - IDLE: start=1 -> CAPTURE. start is ignored in every other state (no queueing).
  - CAPTURE (1 cycle): shreg <= i (the raw functional inputs, regardless of ten); cnt <= 0; -> SHIFT.
  - SHIFT (NCH cycles): shreg <= {tdi, shreg[NCH-1:1]}; cnt++; tdo = shreg[0] (LSB first). When cnt == NCH-1 -> UPDATE.
  - UPDATE (1 cycle): upd <= shreg; done=1; -> IDLE.
- busy = (state != IDLE). Outside SHIFT, tdo = 0.
- Timing, with start sampled at edge k:
  - CAPTURE is the cycle after k.
  - First tdo bit is valid in cycle k+2.
  - done is high in cycle k+NCH+2.
  - New upd is visible on o from cycle k+NCH+3.
- ten toggling mid-sequence does not disturb the FSM; o switches immediately.
- Reset mid-sequence aborts the sequence: upd returns to RESET_VAL and no done pulse is generated.
- NCH=1: SHIFT lasts exactly one cycle.

Optional Feature:
- Macro: DFTPROBE_PARITY_EN.
- When defined:
  - Chain length becomes NCH+1. A parity bit is the last bit shifted in and is held in shreg[NCH].
  - CAPTURE loads shreg[NCH] = ^i, so tdo carries even parity.
  - SHIFT lasts NCH+1 cycles.
  - In UPDATE, if ^shreg[NCH:0] == 1, upd is NOT written and perr is set.
  - perr is sticky until the next accepted start.
- When undefined:
  - Chain length is NCH.
  - perr is tied to 0.

Decomposition:
- Package dftprobe_pkg holds:
  - state enum type (2-bit: IDLE=0, CAPTURE=1, SHIFT=2, UPDATE=3)
  - parity-enable localparam derived from the macro
  - helper function for chain length
- One sub-module, dftprobe_cell: a single channel containing the upd flop with async reset, its reset value, and the ten mux. It is instantiated NCH times via generate.
- The FSM, counter and shift register live in the top module.

Test Plan:
- Reset and transparency: NCH=8, ten=0, i=8'hA5 during and after reset -> o=8'hA5; busy=done=tdo=perr=0; upd=RESET_VAL.
- Capture/observe: i=8'h3C, start pulse -> tdo in cycles k+2..k+9 reads 0,0,1,1,1,1,0,0; done at k+10.
- Force: tdi sequence 1,0,1,0,1,0,1,1 during SHIFT, then ten=1 -> o=8'hD5 from k+11; drop ten -> o=i the same cycle.
- Ignored start and abort:
  - start re-pulsed at k+4 -> no effect, done exactly once.
  - Separately, CELRSTN low at k+5 -> FSM in IDLE, no done, o (ten=1) = RESET_VAL.
- Parity (DFTPROBE_PARITY_EN):
  - Shift 8'hD5 with parity bit 1 -> upd updated, perr=0.
  - Parity bit 0 -> upd unchanged, perr=1 until next start.
- NCH=1 corner: start -> done at k+3; tdo valid in k+2 only.

Source files
------------

// File: rtl/dftprobe_pkg.sv
// dftprobe_pkg: shared types and helpers for the dftprobe_chain scan probe.
// Build option: DFTPROBE_PARITY_EN appends one even-parity bit to the chain.
package dftprobe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } state_e;

`ifdef DFTPROBE_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Serial chain length: one bit per channel plus the optional parity bit.
  function automatic int chain_len(input int nch);
    return nch + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/dftprobe_cell.sv
// dftprobe_cell: one probe channel -- update flop with async reset value and
// the test-enable output mux. Supply pins are carried through with no logic.
module dftprobe_cell
  import dftprobe_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CELCLK,
  input  logic CELRSTN,
  input  logic ld,
  input  logic d,
  input  logic ten,
  input  logic i,
  input  logic CELG,
  input  logic CELSUB,
  input  logic CELV,
  output logic o
);

  logic upd_q;
  logic upd_d;
  logic unused_pwr;

  assign unused_pwr = CELG ^ CELSUB ^ CELV;

  // Hold the forced value unless the chain is committing a new one.
  always_comb begin
    upd_d = upd_q;
    if (ld) upd_d = d;
  end

  // Update latch; reset returns the channel to its configured default.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) upd_q <= RST_VAL;
    else          upd_q <= upd_d;
  end

  assign o = ten ? upd_q : i;

endmodule

// File: rtl/dftprobe_chain.sv
// dftprobe_chain: NCH probe channels behind one capture/shift/update scan
// segment (LSB first on tdo). Build option: DFTPROBE_PARITY_EN adds an
// even-parity bit as the last shifted bit and blocks updates that fail it.
module dftprobe_chain
  import dftprobe_pkg::*;
#(
  parameter int              NCH       = 8,
  parameter logic [NCH-1:0]  RESET_VAL = '0
) (
  input  logic           CELCLK,
  input  logic           CELRSTN,
  input  logic [NCH-1:0] i,
  output logic [NCH-1:0] o,
  input  logic           ten,
  input  logic           start,
  input  logic           tdi,
  output logic           tdo,
  output logic           busy,
  output logic           done,
  output logic           perr,
  input  logic           CELG,
  input  logic           CELSUB,
  input  logic           CELV
);

  localparam int CHL   = chain_len(NCH);
  localparam int CNT_W = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHL - 1);

  state_e           state_q, state_d;
  logic [CHL-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHL-1:0]   capture_vec;
  logic [CHL:0]     shift_cat;
  logic             par_ok;
  logic             upd_ld;

`ifdef DFTPROBE_PARITY_EN
  assign capture_vec = {^i, i};
  assign par_ok      = ~(^shreg_q);
`else
  assign capture_vec = i;
  assign par_ok      = 1'b1;
`endif

  // Concatenate so the right shift also works for a one-bit chain.
  assign shift_cat = {tdi, shreg_q};

  // Sequencer next state, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: begin
        shreg_d = capture_vec;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shift_cat[CHL:1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == UPDATE);
  assign tdo    = (state_q == SHIFT) & shreg_q[0];
  assign upd_ld = (state_q == UPDATE) & par_ok;

`ifdef DFTPROBE_PARITY_EN
  logic perr_q, perr_d;

  // Parity error is sticky until the next accepted start.
  always_comb begin
    perr_d = perr_q;
    if (state_q == IDLE && start)          perr_d = 1'b0;
    else if (state_q == UPDATE && !par_ok) perr_d = 1'b1;
  end

  // Parity error flag register.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_cell
    dftprobe_cell #(
      .RST_VAL(RESET_VAL[g])
    ) u_cell (
      .CELCLK (CELCLK),
      .CELRSTN(CELRSTN),
      .ld     (upd_ld),
      .d      (shreg_q[g]),
      .ten    (ten),
      .i      (i[g]),
      .CELG   (CELG),
      .CELSUB (CELSUB),
      .CELV   (CELV),
      .o      (o[g])
    );
  end

endmodule
